jesd_tx_link_ctrl: RTL and testbench

//  Parametrised JESD204B TX link-layer sequencer, N octets per character clock. Runs the link

---
 rtl/jesd_tx_link_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_jesd_tx_link_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204B TX link-layer sequencer.
// Drives CGS (/K/), then a multi-multiframe ILA sequence, then user data, all
// aligned to an internal LMFC octet counter. Produces pre-8b/10b octets with
// per-octet K flags, N_OCT octets per character clock (octet 0 sent first).
module jesd_tx_link_ctrl #(
   parameter int N_OCT        = 2,
   parameter int F            = 2,
   parameter int K            = 16,
   parameter int ILA_MF       = 4,
   parameter int SYNC_LOW_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_sync_n,
   input  logic [1:0]           i_force_mode,
   input  logic [111:0]         i_ila_cfg,
   input  logic [8*N_OCT-1:0]   i_data,
   input  logic                 i_vld,
   output logic                 o_ready,
   output logic [8*N_OCT-1:0]   o_data,
   output logic [N_OCT-1:0]     o_k,
   output logic                 o_vld,
   output logic [1:0]           o_state,
   output logic                 o_mf_start
);

   localparam int FK = F * K;
   localparam int CW = $clog2(FK);
   localparam int MW = (ILA_MF > 1) ? $clog2(ILA_MF) : 1;
   localparam int SW = $clog2(SYNC_LOW_CYC + 1);

   typedef enum logic [1:0] {
      ST_CGS  = 2'd0,
      ST_ILA  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [MW-1:0]        r_mf;
   logic [SW-1:0]        r_slow;

   logic [8*N_OCT-1:0]   r_o_data;
   logic [N_OCT-1:0]     r_o_k;
   logic                 r_o_vld;
   logic [1:0]           r_o_state;
   logic                 r_o_mfs;
   logic                 r_o_ready;

   state_t               w_state_nxt;
   logic [MW-1:0]        w_mf_cand;
   logic [MW-1:0]        w_mf_nxt;
   logic [SW-1:0]        w_slow_nxt;
   logic [SW-1:0]        w_slow_inc;
   logic                 w_sync_low;
   logic                 w_wrap;
   logic [CW-1:0]        w_cnt_nxt;

   logic [8*N_OCT-1:0]   w_data;
   logic [N_OCT-1:0]     w_k;
   logic                 w_vld;
   logic [31:0]          w_pos;
   logic [7:0]           w_oct;
   logic                 w_koct;

   // The last clock of a multiframe is the one whose successor starts at LMFC position 0.
   assign w_wrap     = (r_cnt == CW'(FK - N_OCT));
   assign w_cnt_nxt  = w_wrap ? {CW{1'b0}} : (r_cnt + CW'(N_OCT));
   assign w_slow_inc = r_slow + SW'(1);
   assign w_sync_low = (r_state != ST_CGS) && !i_sync_n;

   // Next-state logic: force mode first, then the resync counter, then normal link progression.
   always_comb begin
      w_state_nxt = r_state;
      w_mf_cand   = r_mf;
      w_slow_nxt  = {SW{1'b0}};
      case (i_force_mode)
         2'd1: begin
            w_state_nxt = ST_CGS;
         end
         2'd2: begin
            // Forced ILA repeats forever, restarting at multiframe 0 after the last one.
            if (w_wrap) begin
               w_state_nxt = ST_ILA;
               if ((r_state == ST_ILA) && (r_mf != MW'(ILA_MF - 1))) begin
                  w_mf_cand = r_mf + MW'(1);
               end else begin
                  w_mf_cand = {MW{1'b0}};
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         2'd3: begin
            w_state_nxt = ST_DATA;
         end
         default: begin
            if (w_sync_low && (w_slow_inc == SW'(SYNC_LOW_CYC))) begin
               w_state_nxt = ST_CGS;
               w_slow_nxt  = {SW{1'b0}};
            end else begin
               if (w_sync_low) begin
                  w_slow_nxt = w_slow_inc;
               end else begin
                  w_slow_nxt = {SW{1'b0}};
               end
               case (r_state)
                  ST_CGS: begin
                     // Leave CGS only so that ILA begins on an LMFC boundary.
                     if (i_sync_n && w_wrap) begin
                        w_state_nxt = ST_ILA;
                     end else begin
                        w_state_nxt = ST_CGS;
                     end
                  end
                  ST_ILA: begin
                     if (w_wrap) begin
                        if (r_mf == MW'(ILA_MF - 1)) begin
                           w_state_nxt = ST_DATA;
                        end else begin
                           w_mf_cand = r_mf + MW'(1);
                        end
                     end else begin
                        w_state_nxt = ST_ILA;
                     end
                  end
                  ST_DATA: begin
                     w_state_nxt = ST_DATA;
                  end
                  default: begin
                     w_state_nxt = ST_CGS;
                  end
               endcase
            end
         end
      endcase
      // The multiframe index only has meaning inside ILA; it restarts at 0 on every entry.
      w_mf_nxt = (w_state_nxt == ST_ILA) ? w_mf_cand : {MW{1'b0}};
   end

   // Per-octet output content from the current state, LMFC position and inputs.
   always_comb begin
      w_data = {(8*N_OCT){1'b0}};
      w_k    = {N_OCT{1'b0}};
      w_vld  = 1'b0;
      w_pos  = 32'd0;
      w_oct  = 8'h00;
      w_koct = 1'b0;
      for (int i = 0; i < N_OCT; i++) begin
         w_pos = 32'(r_cnt) + 32'(i);
         case (r_state)
            ST_CGS: begin
               w_oct  = 8'hBC;
               w_koct = 1'b1;
               w_vld  = 1'b1;
            end
            ST_ILA: begin
               w_vld = 1'b1;
               if (w_pos == 32'd0) begin
                  w_oct  = 8'h1C;
                  w_koct = 1'b1;
               end else if (w_pos == 32'(FK - 1)) begin
                  w_oct  = 8'h7C;
                  w_koct = 1'b1;
               end else if ((r_mf == MW'(1)) && (w_pos == 32'd1)) begin
                  w_oct  = 8'h9C;
                  w_koct = 1'b1;
               end else if ((r_mf == MW'(1)) && (w_pos >= 32'd2) && (w_pos <= 32'd15)) begin
                  w_oct  = 8'(i_ila_cfg >> ((w_pos - 32'd2) * 32'd8));
                  w_koct = 1'b0;
               end else begin
                  w_oct  = w_pos[7:0];
                  w_koct = 1'b0;
               end
            end
            ST_DATA: begin
               w_vld  = i_vld;
               w_oct  = i_vld ? i_data[8*i +: 8] : 8'h00;
               w_koct = 1'b0;
            end
            default: begin
               w_oct  = 8'h00;
               w_koct = 1'b0;
            end
         endcase
         w_data[8*i +: 8] = w_oct;
         w_k[i]           = w_koct;
      end
   end

   // State, LMFC counter, resync counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_CGS;
         r_cnt     <= {CW{1'b0}};
         r_mf      <= {MW{1'b0}};
         r_slow    <= {SW{1'b0}};
         r_o_data  <= {(8*N_OCT){1'b0}};
         r_o_k     <= {N_OCT{1'b0}};
         r_o_vld   <= 1'b0;
         r_o_state <= 2'd0;
         r_o_mfs   <= 1'b0;
         r_o_ready <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_mf      <= w_mf_nxt;
         r_slow    <= w_slow_nxt;
         r_o_data  <= w_data;
         r_o_k     <= w_k;
         r_o_vld   <= w_vld;
         r_o_state <= r_state;
         r_o_mfs   <= (r_cnt == {CW{1'b0}});
         r_o_ready <= (w_state_nxt == ST_DATA);
      end
   end

   assign o_data     = r_o_data;
   assign o_k        = r_o_k;
   assign o_vld      = r_o_vld;
   assign o_state    = r_o_state;
   assign o_mf_start = r_o_mfs;
   assign o_ready    = r_o_ready;

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Directed bench for jesd_tx_link_ctrl (N_OCT=1, F=2, K=16) with a second
// N_OCT=4 instance sharing the control inputs for word-packing checks.
module tb_jesd_tx_link_ctrl;

   typedef logic [12:0] exp_t; // {data, k, vld, state, mf_start}

   logic          clk = 1'b0;
   logic          rst;
   logic          sync_n;
   logic [1:0]    force_mode;
   logic [111:0]  ila_cfg;
   logic [7:0]    data;
   logic [31:0]   data4;
   logic          vld;

   logic          o_ready;
   logic [7:0]    o_data;
   logic [0:0]    o_k;
   logic          o_vld;
   logic [1:0]    o_state;
   logic          o_mf_start;

   logic          o4_ready;
   logic [31:0]   o4_data;
   logic [3:0]    o4_k;
   logic          o4_vld;
   logic [1:0]    o4_state;
   logic          o4_mf_start;

   int            checks = 0;
   int            errors = 0;
   int            tb_cnt = 0;
   int            j;
   exp_t          q[$];
   string         tq[$];

   always #5 clk = ~clk;

   jesd_tx_link_ctrl #(.N_OCT(1), .F(2), .K(16), .ILA_MF(4), .SYNC_LOW_CYC(4)) u_dut (
      .clk(clk), .rst(rst), .i_sync_n(sync_n), .i_force_mode(force_mode),
      .i_ila_cfg(ila_cfg), .i_data(data), .i_vld(vld), .o_ready(o_ready),
      .o_data(o_data), .o_k(o_k), .o_vld(o_vld), .o_state(o_state),
      .o_mf_start(o_mf_start)
   );

   jesd_tx_link_ctrl #(.N_OCT(4), .F(2), .K(16), .ILA_MF(4), .SYNC_LOW_CYC(4)) u_dut4 (
      .clk(clk), .rst(rst), .i_sync_n(sync_n), .i_force_mode(force_mode),
      .i_ila_cfg(ila_cfg), .i_data(data4), .i_vld(vld), .o_ready(o4_ready),
      .o_data(o4_data), .o_k(o4_k), .o_vld(o4_vld), .o_state(o4_state),
      .o_mf_start(o4_mf_start)
   );

   // Expected ILA octet {k, data} at multiframe m, position p (F*K = 32).
   // The config word holds value c in octet c, so cfg octet p-2 equals p-2.
   function automatic logic [8:0] ila_exp(input int m, input int p);
      if (p == 0)                             return {1'b1, 8'h1C};
      else if (p == 31)                       return {1'b1, 8'h7C};
      else if (m == 1 && p == 1)              return {1'b1, 8'h9C};
      else if (m == 1 && p >= 2 && p <= 15)   return {1'b0, 8'(p - 2)};
      else                                    return {1'b0, 8'(p)};
   endfunction

   task automatic run_cycle(input logic [7:0] d, input logic k, input logic v,
                            input logic [1:0] st, input logic mfs, input string tag);
      exp_t  e;
      exp_t  obs;
      string t;
      q.push_back({d, k, v, st, mfs});
      tq.push_back(tag);
      @(posedge clk);
      @(negedge clk);
      e   = q.pop_front();
      t   = tq.pop_front();
      obs = {o_data, o_k, o_vld, o_state, o_mf_start};
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed data=%h k=%b vld=%b state=%0d mfs=%b, expected data=%h k=%b vld=%b state=%0d mfs=%b",
                t, obs[12:5], obs[4], obs[3], obs[2:1], obs[0], e[12:5], e[4], e[3], e[2:1], e[0]);
      end
   endtask

   task automatic cyc(input logic [7:0] d, input logic k, input logic v,
                      input logic [1:0] st, input string tag);
      run_cycle(d, k, v, st, (tb_cnt == 0), tag);
      tb_cnt = (tb_cnt + 1) % 32;
   endtask

   task automatic chk(input logic [31:0] obs, input logic [31:0] e, input string tag);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   task automatic ila_mf(input int m, input string tag);
      logic [8:0] x;
      for (int p = 0; p < 32; p++) begin
         x = ila_exp(m, p);
         cyc(x[7:0], x[8], 1'b1, 2'd1, tag);
      end
   endtask

   initial begin
      rst        = 1'b1;
      sync_n     = 1'b0;
      force_mode = 2'd0;
      ila_cfg    = 112'h0D0C_0B0A_0908_0706_0504_0302_0100;
      data       = 8'h00;
      data4      = 32'h0;
      vld        = 1'b0;

      // Reset: all outputs zero.
      for (int i = 0; i < 3; i++) run_cycle(8'h00, 1'b0, 1'b0, 2'd0, 1'b0, "reset");
      chk({31'd0, o_ready}, 32'd0, "reset_ready");
      rst = 1'b0;

      // CGS with SYNC~ low.
      for (int i = 0; i < 5; i++) cyc(8'hBC, 1'b1, 1'b1, 2'd0, "cgs");
      chk({31'd0, o_ready}, 32'd0, "cgs_ready");

      // SYNC~ rises at LMFC 5: /K/ continues until the wrap.
      sync_n = 1'b1;
      j = 0;
      do begin
         cyc(8'hBC, 1'b1, 1'b1, 2'd0, "cgs_to_wrap");
         if (j == 3) begin
            chk(o4_data, 32'h0302011C, "n4_first_ila_data");
            chk({28'd0, o4_k}, 32'h1, "n4_first_ila_k");
            chk({29'd0, o4_state, o4_mf_start}, 32'h3, "n4_first_ila_state_mfs");
         end
         if (j == 10) begin
            chk(o4_data, 32'h7C1E1D1C, "n4_last_ila_data");
            chk({28'd0, o4_k}, 32'h8, "n4_last_ila_k");
         end
         j++;
      end while (tb_cnt != 0);

      // Four ILA multiframes, multiframe 1 carries /Q/ and the config.
      ila_mf(0, "ila_m0");
      ila_mf(1, "ila_m1");
      ila_mf(2, "ila_m2");
      ila_mf(3, "ila_m3");
      chk({31'd0, o_ready}, 32'd1, "data_ready");

      // User data.
      data = 8'hA5; vld = 1'b1;
      cyc(8'hA5, 1'b0, 1'b1, 2'd2, "data_a5");
      data = 8'h5A; vld = 1'b0;
      cyc(8'h00, 1'b0, 1'b0, 2'd2, "data_novld");
      for (int i = 0; i < 34; i++) begin
         data = 8'(i * 37 + 11);
         vld  = (i % 3) != 0;
         cyc(vld ? data : 8'h00, 1'b0, vld, 2'd2, "data_pat");
      end

      // Short SYNC~ low pulse is ignored; a long one forces CGS.
      data = 8'h66; vld = 1'b1;
      sync_n = 1'b0;
      for (int i = 0; i < 3; i++) cyc(8'h66, 1'b0, 1'b1, 2'd2, "sync_short");
      sync_n = 1'b1;
      cyc(8'h66, 1'b0, 1'b1, 2'd2, "sync_high");
      sync_n = 1'b0;
      for (int i = 0; i < 4; i++) cyc(8'h66, 1'b0, 1'b1, 2'd2, "sync_long");
      chk({31'd0, o_ready}, 32'd0, "resync_ready");
      cyc(8'hBC, 1'b1, 1'b1, 2'd0, "resync_cgs");
      cyc(8'hBC, 1'b1, 1'b1, 2'd0, "resync_cgs2");

      // Force DATA ignores SYNC~; force CGS returns to /K/.
      force_mode = 2'd3;
      cyc(8'hBC, 1'b1, 1'b1, 2'd0, "force3_edge");
      data = 8'h3C;
      for (int i = 0; i < 6; i++) cyc(8'h3C, 1'b0, 1'b1, 2'd2, "force3_data");
      force_mode = 2'd1;
      cyc(8'h3C, 1'b0, 1'b1, 2'd2, "force1_edge");
      force_mode = 2'd0;
      cyc(8'hBC, 1'b1, 1'b1, 2'd0, "force1_cgs");

      // Force ILA with SYNC~ low: enters at the boundary and loops.
      force_mode = 2'd2;
      do cyc(8'hBC, 1'b1, 1'b1, 2'd0, "force2_wait"); while (tb_cnt != 0);
      for (int mf = 0; mf < 5; mf++) ila_mf(mf % 4, "force2_ila");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
